// File: rtl/otp_stream_cipher.sv
// -----------------------------------------------------------------------------
// otp_stream_cipher
//   One-time-pad stream encryptor. Plaintext bytes are packed MSB-first into
//   words of BYTES_PER_WORD bytes. A word may be closed early with flush, in
//   which case the unused lanes are filled with PAD_BYTE. Each closed word is
//   XORed with exactly one key word from the keypad source and presented
//   downstream. An all-zero key word marks an exhausted keypad and halts the
//   block until reset.
//
// Parameters
//   BYTES_PER_WORD : bytes per word (2..16), word width W = 8*BYTES_PER_WORD
//   PAD_BYTE       : fill byte for a flushed partial word
//   CNT_W          : width of the delivered-word counter
//
// Ports
//   clk           : clock, rising edge
//   reset         : asynchronous active-low reset
//   byte_in/byte_valid/byte_ready : plaintext byte stream
//   flush         : close the current partial word (pad the rest)
//   key_in/key_valid/key_ready    : key word stream, key_ready pulses once per
//                                   consumed key word
//   word_out      : ciphertext word (plaintext ^ key)
//   plain_out     : packed plaintext of the same word
//   word_valid/word_ready         : output word handshake
//   pad_bytes     : number of pad bytes in the word on word_out (0 if full)
//   word_count    : words delivered since reset, wraps
//   key_exhausted : sticky flag, zero key word seen and block halted
// -----------------------------------------------------------------------------
module otp_stream_cipher #(
  parameter int         BYTES_PER_WORD = 4,
  parameter logic [7:0] PAD_BYTE       = 8'h20,
  parameter int         CNT_W          = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [7:0]                           byte_in,
  input  logic                                 byte_valid,
  output logic                                 byte_ready,
  input  logic                                 flush,
  input  logic [8*BYTES_PER_WORD-1:0]          key_in,
  input  logic                                 key_valid,
  output logic                                 key_ready,
  output logic [8*BYTES_PER_WORD-1:0]          word_out,
  output logic [8*BYTES_PER_WORD-1:0]          plain_out,
  output logic                                 word_valid,
  input  logic                                 word_ready,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]  pad_bytes,
  output logic [CNT_W-1:0]                     word_count,
  output logic                                 key_exhausted
);

  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int PW = $clog2(BYTES_PER_WORD + 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_KEY  = 2'd1,
    S_OUT  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_count;
  logic [W-1:0]     r_pack;
  logic [PW-1:0]    r_pad_pend;   // pad count of the word being keyed
  logic [W-1:0]     r_word_out;
  logic [W-1:0]     r_plain_out;
  logic [PW-1:0]    r_pad_out;
  logic [CNT_W-1:0] r_word_count;
  logic             r_key_exh;

  state_t           w_state_nxt;
  logic [PW-1:0]    w_count_nxt;
  logic [PW-1:0]    w_fill_cnt;   // byte count including a same-cycle byte
  logic [W-1:0]     w_pack_nxt;
  logic [PW-1:0]    w_pad_pend_nxt;
  logic [W-1:0]     w_word_out_nxt;
  logic [W-1:0]     w_plain_out_nxt;
  logic [PW-1:0]    w_pad_out_nxt;
  logic [CNT_W-1:0] w_word_count_nxt;
  logic             w_key_exh_nxt;
  logic             w_byte_ready;
  logic             w_key_ready;
  logic             w_word_valid;

  // NOTE: every signal driven here gets a default at the top so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_fill_cnt       = r_count;
    w_pack_nxt       = r_pack;
    w_pad_pend_nxt   = r_pad_pend;
    w_word_out_nxt   = r_word_out;
    w_plain_out_nxt  = r_plain_out;
    w_pad_out_nxt    = r_pad_out;
    w_word_count_nxt = r_word_count;
    w_key_exh_nxt    = r_key_exh;
    w_byte_ready     = 1'b0;
    w_key_ready      = 1'b0;
    w_word_valid     = 1'b0;

    unique case (r_state)
      S_FILL: begin
        w_byte_ready = 1'b1;
        w_fill_cnt   = r_count + PW'(byte_valid);
        // Lane r_count is the next free lane, counted from the MSB end.
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
          if (byte_valid && (r_count == PW'(i))) begin
            w_pack_nxt[W-1-8*i -: 8] = byte_in;
          end
        end
        w_count_nxt = w_fill_cnt;
        if (w_fill_cnt == PW'(BYTES_PER_WORD)) begin
          w_pad_pend_nxt = '0;
          w_state_nxt    = S_KEY;
        end else if (flush && (w_fill_cnt != '0)) begin
          // A byte arriving with flush is already in its lane; pad the rest.
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (PW'(i) >= w_fill_cnt) begin
              w_pack_nxt[W-1-8*i -: 8] = PAD_BYTE;
            end
          end
          w_pad_pend_nxt = PW'(BYTES_PER_WORD) - w_fill_cnt;
          w_state_nxt    = S_KEY;
        end
      end

      S_KEY: begin
        if (key_valid) begin
          if (key_in != '0) begin
            w_key_ready     = 1'b1;
            w_word_out_nxt  = r_pack ^ key_in;
            w_plain_out_nxt = r_pack;
            w_pad_out_nxt   = r_pad_pend;
            w_state_nxt     = S_OUT;
          end else begin
            // All-zero key word marks the end of the keypad: never encrypt
            // with it and never acknowledge it.
            w_key_exh_nxt = 1'b1;
            w_state_nxt   = S_HALT;
          end
        end
      end

      S_OUT: begin
        w_word_valid = 1'b1;
        if (word_ready) begin
          w_word_count_nxt = r_word_count + CNT_W'(1);
          w_count_nxt      = '0;
          w_state_nxt      = S_FILL;
        end
      end

      S_HALT: begin
        w_state_nxt = S_HALT;
      end

      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FILL;
      r_count      <= '0;
      r_pack       <= '0;
      r_pad_pend   <= '0;
      r_word_out   <= '0;
      r_plain_out  <= '0;
      r_pad_out    <= '0;
      r_word_count <= '0;
      r_key_exh    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_pack       <= w_pack_nxt;
      r_pad_pend   <= w_pad_pend_nxt;
      r_word_out   <= w_word_out_nxt;
      r_plain_out  <= w_plain_out_nxt;
      r_pad_out    <= w_pad_out_nxt;
      r_word_count <= w_word_count_nxt;
      r_key_exh    <= w_key_exh_nxt;
    end
  end

  assign byte_ready    = w_byte_ready;
  assign key_ready     = w_key_ready;
  assign word_valid    = w_word_valid;
  assign word_out      = r_word_out;
  assign plain_out     = r_plain_out;
  assign pad_bytes     = r_pad_out;
  assign word_count    = r_word_count;
  assign key_exhausted = r_key_exh;

endmodule

// File: tb/tb_otp_stream_cipher.sv
// -----------------------------------------------------------------------------
// tb_otp_stream_cipher
//   Scoreboard bench for otp_stream_cipher. Two instances share clock and
//   reset: a 4-byte-word instance for most scenarios and an 8-byte-word
//   instance for the wide-word run. Stimulus pushes the expected plaintext,
//   key and pad count; per-instance monitors pop and compare on every output
//   handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_otp_stream_cipher;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // 4-byte instance
  logic [7:0]  byte_in;
  logic        byte_valid, byte_ready, flush;
  logic [31:0] key_in;
  logic        key_valid, key_ready;
  logic [31:0] word_out, plain_out;
  logic        word_valid, word_ready;
  logic [2:0]  pad_bytes;
  logic [15:0] word_count;
  logic        key_exhausted;

  // 8-byte instance
  logic [7:0]  byte_in_8;
  logic        byte_valid_8, byte_ready_8, flush_8;
  logic [63:0] key_in_8;
  logic        key_valid_8, key_ready_8;
  logic [63:0] word_out_8, plain_out_8;
  logic        word_valid_8, word_ready_8;
  logic [3:0]  pad_bytes_8;
  logic [15:0] word_count_8;
  logic        key_exhausted_8;

  otp_stream_cipher #(.BYTES_PER_WORD(4)) u_dut (
    .clk(clk), .reset(reset),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .flush(flush),
    .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .word_out(word_out), .plain_out(plain_out),
    .word_valid(word_valid), .word_ready(word_ready),
    .pad_bytes(pad_bytes), .word_count(word_count),
    .key_exhausted(key_exhausted)
  );

  otp_stream_cipher #(.BYTES_PER_WORD(8)) u_dut8 (
    .clk(clk), .reset(reset),
    .byte_in(byte_in_8), .byte_valid(byte_valid_8), .byte_ready(byte_ready_8),
    .flush(flush_8),
    .key_in(key_in_8), .key_valid(key_valid_8), .key_ready(key_ready_8),
    .word_out(word_out_8), .plain_out(plain_out_8),
    .word_valid(word_valid_8), .word_ready(word_ready_8),
    .pad_bytes(pad_bytes_8), .word_count(word_count_8),
    .key_exhausted(key_exhausted_8)
  );

  typedef struct {
    logic [63:0] plain;
    logic [63:0] key;
    logic [3:0]  pad;
    logic [15:0] cnt;   // word_count value expected while this word is offered
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];
  exp_t e4, e8;

  int n_checks = 0;
  int n_fail   = 0;
  int delivered4 = 0, delivered8 = 0;
  int kr4 = 0, kr8 = 0;
  int exp_cnt4 = 0, exp_cnt8 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (key_ready) kr4++;
    if (reset && word_valid && word_ready) begin
      if (sb4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word4: got %h with empty scoreboard", word_out);
      end else begin
        e4 = sb4.pop_front();
        check("word_out4",   {32'h0, word_out},  e4.plain ^ e4.key);
        check("plain_out4",  {32'h0, plain_out}, e4.plain);
        check("pad_bytes4",  {61'h0, pad_bytes}, {60'h0, e4.pad});
        check("word_count4", {48'h0, word_count}, {48'h0, e4.cnt});
        delivered4++;
      end
    end
  end

  always @(negedge clk) begin
    if (key_ready_8) kr8++;
    if (reset && word_valid_8 && word_ready_8) begin
      if (sb8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word8: got %h with empty scoreboard", word_out_8);
      end else begin
        e8 = sb8.pop_front();
        check("word_out8",   word_out_8,  e8.plain ^ e8.key);
        check("decrypt8",    word_out_8 ^ e8.key, e8.plain);
        check("plain_out8",  plain_out_8, e8.plain);
        check("pad_bytes8",  {60'h0, pad_bytes_8}, {60'h0, e8.pad});
        check("word_count8", {48'h0, word_count_8}, {48'h0, e8.cnt});
        delivered8++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push4(input logic [31:0] plain, input logic [31:0] key, input logic [3:0] pad);
    sb4.push_back('{plain: {32'h0, plain}, key: {32'h0, key}, pad: pad, cnt: 16'(exp_cnt4)});
    exp_cnt4++;
  endtask

  task automatic push8(input logic [63:0] plain, input logic [63:0] key);
    sb8.push_back('{plain: plain, key: key, pad: 4'd0, cnt: 16'(exp_cnt8)});
    exp_cnt8++;
  endtask

  task automatic send4(input logic [7:0] b, input logic f);
    int t = 0;
    @(negedge clk);
    byte_in = b; byte_valid = 1'b1; flush = f;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) check("byte_ready_timeout4", {63'h0, byte_ready}, 64'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic send_bytes4(input logic [31:0] w, input int n, input logic flush_last);
    for (int i = 0; i < n; i++) send4(w[31-8*i -: 8], flush_last && (i == n - 1));
  endtask

  task automatic flush_only4();
    @(negedge clk);
    flush = 1'b1; byte_valid = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic send_bytes8(input logic [63:0] w);
    for (int i = 0; i < 8; i++) begin
      int t = 0;
      @(negedge clk);
      byte_in_8 = w[63-8*i -: 8]; byte_valid_8 = 1'b1;
      while (!byte_ready_8 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!byte_ready_8) check("byte_ready_timeout8", {63'h0, byte_ready_8}, 64'd1);
      @(posedge clk);
      #1;
      byte_valid_8 = 1'b0;
    end
  endtask

  task automatic wait_del4(input int target);
    int t = 0;
    while (delivered4 < target && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("deliver4", 64'(delivered4), 64'(target));
  endtask

  task automatic wait_del8(input int target);
    int t = 0;
    while (delivered8 < target && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("deliver8", 64'(delivered8), 64'(target));
  endtask

  // ---------------- main sequence ----------------
  int kb;
  int d4;

  initial begin
    reset = 1'b0;
    byte_in = '0; byte_valid = 1'b0; flush = 1'b0;
    key_in = '0; key_valid = 1'b0; word_ready = 1'b1;
    byte_in_8 = '0; byte_valid_8 = 1'b0; flush_8 = 1'b0;
    key_in_8 = '0; key_valid_8 = 1'b0; word_ready_8 = 1'b1;
    d4 = 0;

    repeat (3) @(negedge clk);
    check("rst_word_out",   {32'h0, word_out},   64'h0);
    check("rst_plain_out",  {32'h0, plain_out},  64'h0);
    check("rst_word_valid", {63'h0, word_valid}, 64'h0);
    check("rst_pad",        {61'h0, pad_bytes},  64'h0);
    check("rst_word_count", {48'h0, word_count}, 64'h0);
    check("rst_key_exh",    {63'h0, key_exhausted}, 64'h0);
    check("rst_key_ready",  {63'h0, key_ready},  64'h0);
    reset = 1'b1;
    @(negedge clk);
    check("fill_byte_ready", {63'h0, byte_ready}, 64'd1);

    // 1: full word "ABCD"
    key_in = 32'hFFFF0000; key_valid = 1'b1;
    kb = kr4;
    push4(32'h41424344, 32'hFFFF0000, 4'd0);
    send_bytes4(32'h41424344, 4, 1'b0);
    d4++; wait_del4(d4);
    @(negedge clk);
    check("t1_word_count", {48'h0, word_count}, 64'd1);
    check("t1_key_pulses", 64'(kr4 - kb), 64'd1);

    // 2: "AB" then flush
    key_in = 32'h01010101;
    push4(32'h41422020, 32'h01010101, 4'd2);
    send_bytes4(32'h41420000, 2, 1'b0);
    flush_only4();
    d4++; wait_del4(d4);

    // 3: byte and flush together at count 0, then flush alone
    key_in = 32'h12345678;
    push4(32'h5A202020, 32'h12345678, 4'd3);
    send_bytes4(32'h5A000000, 1, 1'b1);
    d4++; wait_del4(d4);
    @(negedge clk);
    kb = kr4;
    flush_only4();
    repeat (5) @(negedge clk);
    check("t3_flush_no_key", 64'(kr4 - kb), 64'd0);
    check("t3_flush_no_word", {63'h0, word_valid}, 64'd0);
    check("t3_flush_count", {48'h0, word_count}, 64'd3);

    // 4: backpressure on the output
    word_ready = 1'b0;
    key_in = 32'hA5A5A5A5;
    push4(32'h31323334, 32'hA5A5A5A5, 4'd0);
    send_bytes4(32'h31323334, 4, 1'b0);
    begin
      int t = 0;
      while (!word_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
    end
    check("t4_valid_seen", {63'h0, word_valid}, 64'd1);
    kb = kr4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_word", {32'h0, word_out}, 64'(32'h31323334 ^ 32'hA5A5A5A5));
      check("t4_hold_flags", {61'h0, byte_ready, key_ready, word_valid}, 64'b001);
    end
    check("t4_hold_no_key", 64'(kr4 - kb), 64'd0);
    check("t4_hold_count", {48'h0, word_count}, 64'd3);
    word_ready = 1'b1;
    d4++; wait_del4(d4);
    @(negedge clk);
    check("t4_release_count", {48'h0, word_count}, 64'd4);

    // 5: zero key word -> halt
    key_in = 32'h0;
    kb = kr4;
    send_bytes4(32'h5758595A, 4, 1'b0);
    repeat (2) @(negedge clk);
    check("t5_exhausted", {63'h0, key_exhausted}, 64'd1);
    for (int i = 0; i < 22; i++) begin
      byte_valid = 1'b1;
      @(negedge clk);
      check("t5_halt_quiet", {61'h0, byte_ready, key_ready, word_valid}, 64'b000);
    end
    byte_valid = 1'b0;
    check("t5_no_key_pulse", 64'(kr4 - kb), 64'd0);
    check("t5_count_frozen", {48'h0, word_count}, 64'd4);
    reset = 1'b0;
    exp_cnt4 = 0; exp_cnt8 = 0;
    @(negedge clk);
    check("t5_rst_exh", {63'h0, key_exhausted}, 64'd0);
    check("t5_rst_count", {48'h0, word_count}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_fill", {63'h0, byte_ready}, 64'd1);

    // 6a: reset after 3 bytes discards them
    key_in = 32'h0F0F0F0F;
    send_bytes4(32'h71727300, 3, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    push4(32'h5758595A, 32'h0F0F0F0F, 4'd0);
    send_bytes4(32'h5758595A, 4, 1'b0);
    d4++; wait_del4(d4);
    @(negedge clk);
    check("t6_count_after_rst", {48'h0, word_count}, 64'd1);

    // 6b: 8-byte words, 16 bytes -> 2 words
    kb = kr8;
    key_in_8 = 64'h0123456789ABCDEF; key_valid_8 = 1'b1;
    push8(64'h3031323334353637, 64'h0123456789ABCDEF);
    send_bytes8(64'h3031323334353637);
    wait_del8(1);
    key_in_8 = 64'hFEDCBA9876543210;
    push8(64'h3839414243444546, 64'hFEDCBA9876543210);
    send_bytes8(64'h3839414243444546);
    wait_del8(2);
    @(negedge clk);
    check("t6_count8", {48'h0, word_count_8}, 64'd2);
    check("t6_key_pulses8", 64'(kr8 - kb), 64'd2);
    check("sb_empty", 64'(sb4.size() + sb8.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
